// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM stage: FSM state encodings, default widths,
// the default timeout, and the latched-control bundle carried across WAIT.
package mem_access_stage_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_WAIT = 1'b1;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_REG_W   = 5;
  localparam int DEF_TIMEOUT = 16;

  // Control bits that must survive the WAIT state.
  typedef struct packed {
    logic is_load;     // read without write; memRead&memWrite is a store
    logic reg_write;
    logic mem_to_reg;
  } mem_ctrl_t;

endpackage

// File: rtl/mem_access_stage_wait_timer.sv
// Timeout counter for the MEM stage WAIT state.
// Ports:
//   clk, rst_n  clock / async active-low reset
//   clr         force count to 0 (held while the FSM is idle)
//   en          advance the count by one this cycle
//   expired     count has reached TIMEOUT-1 (final wait cycle)
module mem_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == CW'(TIMEOUT - 1));

  // en is never raised on the final count, so the counter cannot wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: takes the EX/MEM bundle, performs the data-memory
// access over a req/ack bus, resolves the branch and drives MEM/WB.
// Ports:
//   EX/MEM in : valid_in, pcAdded, zeroFlag, aluResult, writeData,
//               muxRegFileData, branch, memWrite, memRead, regWrite, memToReg
//   control   : stall (hold upstream), pc_src / branch_target (branch redirect)
//   memory    : mem_req, mem_we, mem_addr, mem_wdata out; mem_rdata, mem_ack in
//   MEM/WB out: wb_valid, wb_readData, wb_aluResult, wb_regDst, wb_regWrite,
//               wb_memToReg
//   status    : mem_err (sticky timeout)
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int REG_W   = DEF_REG_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] pcAdded,
  input  logic [DATA_W-1:0] zeroFlag,
  input  logic [DATA_W-1:0] aluResult,
  input  logic [DATA_W-1:0] writeData,
  input  logic [REG_W-1:0]  muxRegFileData,
  input  logic              branch,
  input  logic              memWrite,
  input  logic              memRead,
  input  logic              regWrite,
  input  logic              memToReg,
  output logic              stall,
  output logic              pc_src,
  output logic [DATA_W-1:0] branch_target,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_readData,
  output logic [DATA_W-1:0] wb_aluResult,
  output logic [REG_W-1:0]  wb_regDst,
  output logic              wb_regWrite,
  output logic              wb_memToReg,
  output logic              mem_err
);

  logic              state_q, state_d;
  logic              mem_req_q, mem_we_q, mem_err_q;
  logic [DATA_W-1:0] mem_addr_q, mem_wdata_q;
  logic [REG_W-1:0]  dst_q;
  mem_ctrl_t         ctrl_q;
  logic              wb_valid_q, wb_regWrite_q, wb_memToReg_q;
  logic [DATA_W-1:0] wb_readData_q, wb_aluResult_q;
  logic [REG_W-1:0]  wb_regDst_q;

  logic in_wait, accept, is_mem, expired, done_ack, done_abort;

  assign in_wait    = (state_q == ST_WAIT);
  assign accept     = ~in_wait & valid_in;
  assign is_mem     = memRead | memWrite;
  assign done_ack   = in_wait & mem_ack;
  // Ack on the final count takes priority over the abort.
  assign done_abort = in_wait & ~mem_ack & expired;

  assign stall         = in_wait & ~mem_ack & ~expired;
  assign pc_src        = accept & branch & (|zeroFlag);
  assign branch_target = pcAdded;

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (~in_wait),
    .en      (in_wait & ~mem_ack & ~expired),
    .expired (expired)
  );

  always_comb begin
    state_d = state_q;
    if (accept & is_mem)          state_d = ST_WAIT;
    else if (done_ack | done_abort) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      mem_req_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      dst_q          <= '0;
      ctrl_q         <= '0;
      mem_err_q      <= 1'b0;
      wb_valid_q     <= 1'b0;
      wb_readData_q  <= '0;
      wb_aluResult_q <= '0;
      wb_regDst_q    <= '0;
      wb_regWrite_q  <= 1'b0;
      wb_memToReg_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wb_valid_q <= 1'b0;
      if (accept) begin
        if (is_mem) begin
          mem_req_q      <= 1'b1;
          mem_we_q       <= memWrite;
          mem_addr_q     <= aluResult;
          mem_wdata_q    <= writeData;
          dst_q          <= muxRegFileData;
          ctrl_q.is_load    <= memRead & ~memWrite;
          ctrl_q.reg_write  <= regWrite;
          ctrl_q.mem_to_reg <= memToReg;
        end else begin
          wb_valid_q     <= 1'b1;
          wb_readData_q  <= '0;
          wb_aluResult_q <= aluResult;
          wb_regDst_q    <= muxRegFileData;
          wb_regWrite_q  <= regWrite;
          wb_memToReg_q  <= memToReg;
        end
      end else if (done_ack | done_abort) begin
        mem_req_q      <= 1'b0;
        wb_valid_q     <= 1'b1;
        wb_aluResult_q <= mem_addr_q;
        wb_regDst_q    <= dst_q;
        wb_memToReg_q  <= ctrl_q.mem_to_reg;
        // Aborted accesses must not write the register file.
        wb_regWrite_q  <= done_ack & ctrl_q.reg_write;
        wb_readData_q  <= (done_ack & ctrl_q.is_load) ? mem_rdata : '0;
        if (done_abort) mem_err_q <= 1'b1;
      end
    end

  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_err      = mem_err_q;
  assign wb_valid     = wb_valid_q;
  assign wb_readData  = wb_readData_q;
  assign wb_aluResult = wb_aluResult_q;
  assign wb_regDst    = wb_regDst_q;
  assign wb_regWrite  = wb_regWrite_q;
  assign wb_memToReg  = wb_memToReg_q;

endmodule
